// File: rtl/pipe_mem.sv
// pipe_mem: MEM stage of the 5-stage pipeline, between EX and WB.
//   Holds one instruction. Loads wait for the data-memory response, whose word
//   is then aligned and sign/zero-extended into the write-back value.
// Ports:
//   clk, reset (async, active-high)
//   from_valid/from_pc, to_allowin            - handshake with EX
//   to_valid, next_allowin                    - handshake with WB
//   rf_we_EX, rf_waddr_EX, alu_result_EX,
//   res_from_mem_EX, mem_op_EX                - instruction fields from EX
//   data_data_ok, data_rdata                  - data-memory read response
//   rf_we, rf_waddr, rf_wdata                 - write-back fields to WB
//   fwd_we, fwd_waddr, fwd_wdata, fwd_pending - forwarding/stall view for ID
//   PC                                        - PC of the held instruction
//
// state  | meaning
// EMPTY  | no instruction held
// WAIT   | load held, memory response not yet seen
// READY  | result final (non-load, or load data captured in rdata_q)
module pipe_mem #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        from_valid,
  input  logic [31:0] from_pc,
  output logic        to_allowin,
  output logic        to_valid,
  input  logic        next_allowin,
  input  logic        rf_we_EX,
  input  logic [4:0]  rf_waddr_EX,
  input  logic [31:0] alu_result_EX,
  input  logic        res_from_mem_EX,
  input  logic [2:0]  mem_op_EX,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        fwd_we,
  output logic [4:0]  fwd_waddr,
  output logic [31:0] fwd_wdata,
  output logic        fwd_pending,
  output logic [31:0] PC
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic        res_from_mem_q, res_from_mem_d;
  logic [2:0]  mem_op_q, mem_op_d;
  logic [31:0] rdata_q, rdata_d;

  logic        ready_go;
  logic        accept;
  logic        leave;
  logic        valid;
  logic [31:0] load_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  // held instruction fields and the load-data buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= 5'd0;
      alu_result_q   <= 32'd0;
      res_from_mem_q <= 1'b0;
      mem_op_q       <= 3'd0;
      rdata_q        <= 32'd0;
    end else begin
      pc_q           <= pc_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      alu_result_q   <= alu_result_d;
      res_from_mem_q <= res_from_mem_d;
      mem_op_q       <= mem_op_d;
      rdata_q        <= rdata_d;
    end
  end

  // next-state and next-field logic
  always_comb begin
    ready_go       = (state_q == S_READY) || ((state_q == S_WAIT) && data_data_ok);
    to_allowin     = (state_q == S_EMPTY) || (ready_go && next_allowin);
    accept         = from_valid && to_allowin;
    leave          = ready_go && next_allowin;
    state_d        = state_q;
    pc_d           = pc_q;
    rf_we_d        = rf_we_q;
    rf_waddr_d     = rf_waddr_q;
    alu_result_d   = alu_result_q;
    res_from_mem_d = res_from_mem_q;
    mem_op_d       = mem_op_q;
    rdata_d        = rdata_q;
    if (accept) begin
      state_d        = res_from_mem_EX ? S_WAIT : S_READY;
      pc_d           = from_pc;
      rf_we_d        = rf_we_EX;
      rf_waddr_d     = rf_waddr_EX;
      alu_result_d   = alu_result_EX;
      res_from_mem_d = res_from_mem_EX;
      mem_op_d       = mem_op_EX;
    end else if (leave) begin
      state_d = S_EMPTY;
    end else if ((state_q == S_WAIT) && data_data_ok) begin
      // response arrived while WB stalls: keep it, the bus will not hold it
      state_d = S_READY;
      rdata_d = data_rdata;
    end
  end

  // outputs
  always_comb begin
    valid     = (state_q != S_EMPTY);
    to_valid  = ready_go;
    // in WAIT the word comes straight off the bus; once captured, from the buffer
    load_word = (state_q == S_WAIT) ? data_rdata : rdata_q;
    case (alu_result_q[1:0])
      2'd0:    byte_sel = load_word[7:0];
      2'd1:    byte_sel = load_word[15:8];
      2'd2:    byte_sel = load_word[23:16];
      default: byte_sel = load_word[31:24];
    endcase
    half_sel = alu_result_q[1] ? load_word[31:16] : load_word[15:0];
    case (mem_op_q)
      3'b001:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b101:  load_data = {24'd0, byte_sel};
      3'b010:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b110:  load_data = {16'd0, half_sel};
      default: load_data = load_word;
    endcase
    rf_we       = valid && rf_we_q;
    rf_waddr    = rf_waddr_q;
    rf_wdata    = res_from_mem_q ? load_data : alu_result_q;
    fwd_we      = rf_we && (rf_waddr_q != 5'd0);
    fwd_waddr   = rf_waddr_q;
    fwd_wdata   = rf_wdata;
    fwd_pending = (state_q == S_WAIT) && !data_data_ok;
    PC          = pc_q;
  end

endmodule

// File: tb/tb_pipe_mem.sv
module tb_pipe_mem;

  localparam logic [31:0] RST_PC = 32'h1bff_fffc;

  logic        clk = 1'b0;
  logic        reset;
  logic        from_valid;
  logic [31:0] from_pc;
  logic        to_allowin;
  logic        to_valid;
  logic        next_allowin;
  logic        rf_we_EX;
  logic [4:0]  rf_waddr_EX;
  logic [31:0] alu_result_EX;
  logic        res_from_mem_EX;
  logic [2:0]  mem_op_EX;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_we;
  logic [4:0]  fwd_waddr;
  logic [31:0] fwd_wdata;
  logic        fwd_pending;
  logic [31:0] PC;

  pipe_mem #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .from_valid(from_valid), .from_pc(from_pc), .to_allowin(to_allowin),
    .to_valid(to_valid), .next_allowin(next_allowin),
    .rf_we_EX(rf_we_EX), .rf_waddr_EX(rf_waddr_EX), .alu_result_EX(alu_result_EX),
    .res_from_mem_EX(res_from_mem_EX), .mem_op_EX(mem_op_EX),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .fwd_pending(fwd_pending), .PC(PC)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every handoff to WB is compared against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (to_valid && next_allowin) begin
        if (q.size() == 0) begin
          chk("unexpected_handoff", PC, 32'hffff_ffff);
        end else begin
          e = q.pop_front();
          chk("wb_pc", PC, e.pc);
          chk("wb_rf_we", {31'd0, rf_we}, {31'd0, e.we});
          chk("wb_waddr", {27'd0, rf_waddr}, {27'd0, e.waddr});
          chk("wb_wdata", rf_wdata, e.wdata);
          chk("wb_fwd_we", {31'd0, fwd_we}, {31'd0, e.we && (e.waddr != 5'd0)});
          chk("wb_fwd_wdata", fwd_wdata, e.wdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // drive one EX instruction; returns at posedge+1 after it was accepted
  task automatic issue(input logic [31:0] pc, input logic we, input logic [4:0] waddr,
                       input logic [31:0] alu, input logic ld, input logic [2:0] op,
                       input logic [31:0] exp_wdata, input bit keep, output int waits);
    exp_t e;
    from_valid      = 1'b1;
    from_pc         = pc;
    rf_we_EX        = we;
    rf_waddr_EX     = waddr;
    alu_result_EX   = alu;
    res_from_mem_EX = ld;
    mem_op_EX       = op;
    e.pc = pc; e.we = we; e.waddr = waddr; e.wdata = exp_wdata;
    q.push_back(e);
    waits = 0;
    @(negedge clk);
    while (!to_allowin && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!to_allowin) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (!keep) from_valid = 1'b0;
  endtask

  initial begin
    int w;
    reset = 1'b1; from_valid = 1'b0; from_pc = 32'd0; next_allowin = 1'b1;
    rf_we_EX = 1'b0; rf_waddr_EX = 5'd0; alu_result_EX = 32'd0;
    res_from_mem_EX = 1'b0; mem_op_EX = 3'd0; data_data_ok = 1'b0; data_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_to_valid", {31'd0, to_valid}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_fwd_we", {31'd0, fwd_we}, 32'd0);
    chk("rst_fwd_pending", {31'd0, fwd_pending}, 32'd0);
    chk("rst_pc", PC, RST_PC);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: ALU instruction
    issue(32'h1c00_0010, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 3'b000, 32'h0000_1234, 1'b0, w);
    @(negedge clk);
    chk("t1_to_valid", {31'd0, to_valid}, 32'd1);
    chk("t1_wdata", rf_wdata, 32'h0000_1234);
    chk("t1_fwd_we", {31'd0, fwd_we}, 32'd1);
    @(posedge clk); #1;

    // 2: LB / LBU at byte 3, response one cycle after accept
    issue(32'h1c00_0020, 1'b1, 5'd6, 32'h0000_1003, 1'b1, 3'b001, 32'hffff_ff80, 1'b0, w);
    data_data_ok = 1'b1; data_rdata = 32'h80ff_0000;
    @(negedge clk);
    chk("t2_lb_to_valid", {31'd0, to_valid}, 32'd1);
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    issue(32'h1c00_0024, 1'b1, 5'd7, 32'h0000_1003, 1'b1, 3'b101, 32'h0000_0080, 1'b0, w);
    data_data_ok = 1'b1;
    @(posedge clk); #1;
    data_data_ok = 1'b0;

    // 3: LH upper half, response delayed 3 cycles
    data_rdata = 32'h8001_1234;
    issue(32'h1c00_0030, 1'b1, 5'd9, 32'h0000_2002, 1'b1, 3'b010, 32'hffff_8001, 1'b0, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_fwd_pending", {31'd0, fwd_pending}, 32'd1);
      chk("t3_to_allowin", {31'd0, to_allowin}, 32'd0);
      @(posedge clk); #1;
    end
    data_data_ok = 1'b1;
    @(negedge clk);
    chk("t3_to_valid", {31'd0, to_valid}, 32'd1);
    chk("t3_fwd_pending_clr", {31'd0, fwd_pending}, 32'd0);
    @(posedge clk); #1;
    data_data_ok = 1'b0;

    // 4: LW response arrives while WB stalls; bus then drops the word
    next_allowin = 1'b0;
    issue(32'h1c00_0040, 1'b1, 5'd8, 32'h0000_3000, 1'b1, 3'b000, 32'hdead_beef, 1'b0, w);
    data_data_ok = 1'b1; data_rdata = 32'hdead_beef;
    @(posedge clk); #1;
    data_data_ok = 1'b0; data_rdata = 32'd0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t4_hold_wdata", rf_wdata, 32'hdead_beef);
      chk("t4_hold_valid", {31'd0, to_valid}, 32'd1);
      chk("t4_hold_allowin", {31'd0, to_allowin}, 32'd0);
      @(posedge clk); #1;
    end
    next_allowin = 1'b1;
    @(posedge clk); #1;

    // 5: back-to-back non-loads, one with rf_we=0 and one writing r0
    issue(32'h1c00_0050, 1'b1, 5'd10, 32'h0000_00a0, 1'b0, 3'b000, 32'h0000_00a0, 1'b1, w);
    chk("t5_wait0", w, 0);
    issue(32'h1c00_0054, 1'b0, 5'd11, 32'h0000_00b0, 1'b0, 3'b000, 32'h0000_00b0, 1'b1, w);
    chk("t5_wait1", w, 0);
    issue(32'h1c00_0058, 1'b1, 5'd0, 32'h0000_00c0, 1'b0, 3'b000, 32'h0000_00c0, 1'b1, w);
    chk("t5_wait2", w, 0);
    issue(32'h1c00_005c, 1'b1, 5'd12, 32'h0000_00d0, 1'b0, 3'b000, 32'h0000_00d0, 1'b0, w);
    chk("t5_wait3", w, 0);
    @(negedge clk);
    chk("t5_last_valid", {31'd0, to_valid}, 32'd1);
    @(posedge clk); #1;

    // 6: reset during WAIT, then a stray response
    issue(32'h1c00_0060, 1'b1, 5'd13, 32'h0000_4000, 1'b1, 3'b000, 32'h0000_0000, 1'b0, w);
    reset = 1'b1;
    void'(q.pop_back());
    #1;
    chk("t6_valid", {31'd0, to_valid}, 32'd0);
    chk("t6_rf_we", {31'd0, rf_we}, 32'd0);
    chk("t6_pc", PC, RST_PC);
    @(posedge clk); #1;
    reset = 1'b0;
    data_data_ok = 1'b1; data_rdata = 32'h5555_5555;
    @(negedge clk);
    chk("t6_stray_valid", {31'd0, to_valid}, 32'd0);
    chk("t6_stray_allowin", {31'd0, to_allowin}, 32'd1);
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    @(negedge clk);
    chk("t6_after_valid", {31'd0, to_valid}, 32'd0);
    chk("t6_after_pc", PC, RST_PC);
    @(posedge clk); #1;
    issue(32'h1c00_0070, 1'b1, 5'd14, 32'h0000_5001, 1'b1, 3'b110, 32'h0000_a5a5, 1'b0, w);
    @(negedge clk);
    chk("t6_new_pending", {31'd0, fwd_pending}, 32'd1);
    @(posedge clk); #1;
    data_data_ok = 1'b1; data_rdata = 32'h1234_a5a5;
    @(posedge clk); #1;
    data_data_ok = 1'b0;

    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
